// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown display: FSM state codes,
// digit index codes and the active-high gfedcba segment encoder.
package countdown_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CONV = 2'd1;
  localparam state_t ST_LOAD = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  localparam logic [1:0] DIGIT_ONES  = 2'd0;
  localparam logic [1:0] DIGIT_TENS  = 2'd1;
  localparam logic [1:0] DIGIT_PHASE = 2'd2;

  localparam int CONV_STEPS = 7;

  // Codes 10..15 never reach the encoder in normal use; they render blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 7-bit binary to hundreds/tens/ones BCD
// in exactly 7 shift iterations, with a one-cycle LOAD state signalling done.
module bin2bcd_seq
  import countdown_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [6:0] i_value,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_ovf
);

  state_t      r_state;
  logic [2:0]  r_iter;
  // {hundreds, tens, ones, remaining binary bits}
  logic [18:0] r_shift;
  logic [11:0] w_adj;
  logic [18:0] w_pre;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_shift[7+gi*4 +: 4] >= 4'd5) ?
                                (r_shift[7+gi*4 +: 4] + 4'd3) :
                                r_shift[7+gi*4 +: 4];
    end
  endgenerate

  assign w_pre = {w_adj, r_shift[6:0]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_iter  <= 3'd0;
      r_shift <= 19'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_shift <= {12'd0, i_value};
            r_iter  <= 3'd0;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_shift <= w_pre << 1;
          if (r_iter == 3'(CONV_STEPS - 1)) begin
            r_state <= ST_LOAD;
          end else begin
            r_iter <= r_iter + 3'd1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = (r_state == ST_LOAD);
  assign o_ones = r_shift[10:7];
  assign o_tens = r_shift[14:11];
  assign o_ovf  = |r_shift[18:15];

endmodule

// File: rtl/countdown_display.sv
// Countdown display driver: converts remaining time to BCD and scans tens, ones
// and phase digits onto one 7-segment bus. Option macro: BLANK_LEADING_ZERO_EN.
module countdown_display
  import countdown_pkg::*;
#(
  parameter int SCAN_DIV       = 16,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [6:0] i_value,
  input  logic [1:0] i_phase,
  output logic [6:0] o_seg,
  output logic [2:0] o_an,
  output logic       o_busy,
  output logic       o_bcd_valid,
  output logic       o_ovf
);

  logic                r_pending;
  logic [6:0]          r_held_value;
  logic [1:0]          r_held_phase;
  logic [SCAN_DIV-1:0] r_prescale;
  logic [1:0]          r_digit_idx;
  logic [3:0]          r_ones;
  logic [3:0]          r_tens;
  logic [1:0]          r_phase_disp;
  logic                r_ovf;
  logic                r_bcd_valid;
  logic [6:0]          r_seg;
  logic [2:0]          r_an;

  logic                w_start;
  logic                w_busy;
  logic                w_done;
  logic [3:0]          w_conv_tens;
  logic [3:0]          w_conv_ones;
  logic                w_conv_ovf;

  logic [3:0]          w_ones_next;
  logic [3:0]          w_tens_next;
  logic [1:0]          w_phase_disp_next;
  logic                w_ovf_next;
  logic [SCAN_DIV-1:0] w_prescale_next;
  logic [1:0]          w_idx_next;
  logic [6:0]          w_ones_seg;
  logic [6:0]          w_tens_seg;
  logic [6:0]          w_seg_next;
  logic [2:0]          w_an_next;

  assign w_start = !w_busy &&
                   (r_pending || (i_value != r_held_value) || (i_phase != r_held_phase));

  bin2bcd_seq u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_start),
    .i_value (i_value),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_tens  (w_conv_tens),
    .o_ones  (w_conv_ones),
    .o_ovf   (w_conv_ovf)
  );

  // Segments are registered from next-state values so seg/an always agree with
  // the digit index and the display registers of the same cycle.
  always_comb begin
    w_ones_next       = r_ones;
    w_tens_next       = r_tens;
    w_phase_disp_next = r_phase_disp;
    w_ovf_next        = r_ovf;
    if (w_done) begin
      w_ones_next       = w_conv_ones;
      w_tens_next       = w_conv_tens;
      w_phase_disp_next = r_held_phase;
      w_ovf_next        = w_conv_ovf;
    end
  end

  always_comb begin
    w_prescale_next = '0;
    w_idx_next      = DIGIT_ONES;
    if (i_en) begin
      w_prescale_next = r_prescale + 1'b1;
      w_idx_next      = r_digit_idx;
      if (r_prescale == '1) begin
        w_idx_next = (r_digit_idx == DIGIT_PHASE) ? DIGIT_ONES : (r_digit_idx + 2'd1);
      end
    end
  end

  always_comb begin
    w_ones_seg = w_ovf_next ? SEG_DASH : digit_to_seg(w_ones_next);
    if (w_ovf_next) begin
      w_tens_seg = SEG_DASH;
    end else begin
`ifdef BLANK_LEADING_ZERO_EN
      w_tens_seg = (w_tens_next == 4'd0) ? SEG_BLANK : digit_to_seg(w_tens_next);
`else
      w_tens_seg = digit_to_seg(w_tens_next);
`endif
    end
  end

  always_comb begin
    w_seg_next = SEG_BLANK;
    w_an_next  = 3'b000;
    if (i_en) begin
      case (w_idx_next)
        DIGIT_ONES: begin
          w_an_next  = 3'b001;
          w_seg_next = w_ones_seg;
        end
        DIGIT_TENS: begin
          w_an_next  = 3'b010;
          w_seg_next = w_tens_seg;
        end
        DIGIT_PHASE: begin
          w_an_next  = 3'b100;
          w_seg_next = digit_to_seg({2'b00, w_phase_disp_next});
        end
        default: begin
          w_an_next  = 3'b000;
          w_seg_next = SEG_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending    <= 1'b1;
      r_held_value <= 7'd0;
      r_held_phase <= 2'd0;
      r_prescale   <= '0;
      r_digit_idx  <= DIGIT_ONES;
      r_ones       <= 4'd0;
      r_tens       <= 4'd0;
      r_phase_disp <= 2'd0;
      r_ovf        <= 1'b0;
      r_bcd_valid  <= 1'b0;
      r_seg        <= SEG_BLANK;
      r_an         <= 3'b000;
    end else begin
      if (w_start) begin
        r_held_value <= i_value;
        r_held_phase <= i_phase;
        r_pending    <= 1'b0;
      end
      if (w_done) begin
        r_bcd_valid <= 1'b1;
      end
      r_ones       <= w_ones_next;
      r_tens       <= w_tens_next;
      r_phase_disp <= w_phase_disp_next;
      r_ovf        <= w_ovf_next;
      r_prescale   <= w_prescale_next;
      r_digit_idx  <= w_idx_next;
      r_seg        <= w_seg_next;
      r_an         <= w_an_next;
    end
  end

  assign o_seg       = ACTIVE_LOW_SEG ? ~r_seg : r_seg;
  assign o_an        = ACTIVE_LOW_SEG ? ~r_an : r_an;
  assign o_busy      = w_busy;
  assign o_bcd_valid = r_bcd_valid;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display (SCAN_DIV=2, active-high outputs).
module tb_countdown_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [6:0] value;
  logic [1:0] phase;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;
  logic       bcd_valid;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  countdown_display #(
    .SCAN_DIV       (2),
    .ACTIVE_LOW_SEG (1'b0)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_value     (value),
    .i_phase     (phase),
    .o_seg       (seg),
    .o_an        (an),
    .o_busy      (busy),
    .o_bcd_valid (bcd_valid),
    .o_ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'h3F; 1: s = 7'h06; 2: s = 7'h5B; 3: s = 7'h4F; 4: s = 7'h66;
      5: s = 7'h6D; 6: s = 7'h7D; 7: s = 7'h07; 8: s = 7'h7F; 9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; value = 7'd0; phase = 2'd0;
    step(2);
    checks++; if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h want 00", seg); end
    checks++; if (an !== 3'b000) begin errors++; $display("FAIL reset_an: got %b want 000", an); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bcd_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pending_busy: got %b want 1", busy); end
      end
      if (k == 8) begin
        checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL valid_early: got %b want 0 at clk 8", bcd_valid); end
      end
      if (k == 9) begin
        checks++; if (bcd_valid !== 1'b1) begin errors++; $display("FAIL valid_clk9: got %b want 1", bcd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_clk9: got %b want 0", busy); end
      end
    end
    $display("reset: errors=%0d", errors);
  endtask

  task automatic test_scan();
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    value = 7'd59; phase = 2'd1;
    step(8);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL scan_busy8: got %b want 1", busy); end
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scan_busy9: got %b want 0", busy); end
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k <= 3 || k == 12) begin exp_an = 3'b001; exp_seg = 7'h6F; end
      else if (k <= 7)       begin exp_an = 3'b010; exp_seg = 7'h6D; end
      else                   begin exp_an = 3'b100; exp_seg = 7'h06; end
      checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an k=%0d: got %b want %b", k, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg k=%0d: got %h want %h", k, seg, exp_seg); end
    end
    $display("scan 59/1: errors=%0d", errors);
  endtask

  task automatic test_ovf();
    en = 1'b0; value = 7'd100;
    step(8);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ovf); end
    step(1);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
    en = 1'b1;
    step(1);
    checks++; if (seg !== 7'h40 || an !== 3'b001) begin errors++; $display("FAIL ovf_ones: got %h/%b want 40/001", seg, an); end
    step(3);
    checks++; if (seg !== 7'h40 || an !== 3'b010) begin errors++; $display("FAIL ovf_tens: got %h/%b want 40/010", seg, an); end
    en = 1'b0; value = 7'd99;
    step(8);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", ovf); end
    step(1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_99: got %b want 0", ovf); end
    en = 1'b1;
    step(1);
    checks++; if (seg !== 7'h6F || an !== 3'b001) begin errors++; $display("FAIL n99_ones: got %h/%b want 6f/001", seg, an); end
    step(3);
    checks++; if (seg !== 7'h6F || an !== 3'b010) begin errors++; $display("FAIL n99_tens: got %h/%b want 6f/010", seg, an); end
    $display("ovf 100/99: errors=%0d", errors);
  endtask

  task automatic test_back_to_back();
    int eo, et;
    logic [6:0] exp_seg;
    value = 7'd45;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 3) value = 7'd12;
      if (k < 9)       begin eo = 9; et = 9; end
      else if (k < 18) begin eo = 5; et = 4; end
      else             begin eo = 2; et = 1; end
      case (an)
        3'b001:  exp_seg = seg_of(eo);
        3'b010:  exp_seg = seg_of(et);
        3'b100:  exp_seg = seg_of(1);
        default: exp_seg = 7'h00;
      endcase
      checks++;
      if (an != 3'b001 && an != 3'b010 && an != 3'b100) begin
        errors++; $display("FAIL b2b_an k=%0d: got %b want one-hot", k, an);
      end else if (seg !== exp_seg) begin
        errors++; $display("FAIL b2b_seg k=%0d: got %h want %h (an %b)", k, seg, exp_seg, an);
      end
      if (k == 9 || k == 18) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy k=%0d: got %b want 0", k, busy); end
      end
      if (k == 10) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", busy); end
      end
    end
    $display("back_to_back 45->12: errors=%0d", errors);
  endtask

  task automatic test_enable();
    en = 1'b0;
    step(1);
    checks++; if (an !== 3'b000 || seg !== 7'h00) begin errors++; $display("FAIL en_blank: got %h/%b want 00/000", seg, an); end
    value = 7'd33;
    step(9);
    checks++; if (busy !== 1'b0 || an !== 3'b000) begin errors++; $display("FAIL en_conv: busy %b an %b want 0/000", busy, an); end
    en = 1'b1;
    step(1);
    checks++; if (seg !== 7'h4F || an !== 3'b001) begin errors++; $display("FAIL en_ones: got %h/%b want 4f/001", seg, an); end
    step(3);
    checks++; if (seg !== 7'h4F || an !== 3'b010) begin errors++; $display("FAIL en_tens: got %h/%b want 4f/010", seg, an); end
    $display("enable 33: errors=%0d", errors);
  endtask

  task automatic test_leading_zero();
    logic [6:0] exp_tens;
`ifdef BLANK_LEADING_ZERO_EN
    exp_tens = 7'h00;
`else
    exp_tens = 7'h3F;
`endif
    en = 1'b0; value = 7'd7; phase = 2'd2;
    step(9);
    en = 1'b1;
    step(1);
    checks++; if (seg !== 7'h07 || an !== 3'b001) begin errors++; $display("FAIL lz_ones: got %h/%b want 07/001", seg, an); end
    step(3);
    checks++; if (seg !== exp_tens || an !== 3'b010) begin errors++; $display("FAIL lz_tens: got %h/%b want %h/010", seg, an, exp_tens); end
    step(4);
    checks++; if (seg !== 7'h5B || an !== 3'b100) begin errors++; $display("FAIL lz_phase: got %h/%b want 5b/100", seg, an); end
    $display("leading_zero 7/2: errors=%0d", errors);
  endtask

  task automatic test_reset_midconv();
    en = 1'b0; value = 7'd50;
    step(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    step(1);
    checks++; if (busy !== 1'b0 || bcd_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL mid_reset: busy %b valid %b ovf %b want 0/0/0", busy, bcd_valid, ovf);
    end
    rst_n = 1'b1;
    step(8);
    checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL mid_valid8: got %b want 0", bcd_valid); end
    step(1);
    checks++; if (bcd_valid !== 1'b1) begin errors++; $display("FAIL mid_valid9: got %b want 1", bcd_valid); end
    en = 1'b1;
    step(1);
    checks++; if (seg !== 7'h3F || an !== 3'b001) begin errors++; $display("FAIL mid_ones: got %h/%b want 3f/001", seg, an); end
    step(3);
    checks++; if (seg !== 7'h6D || an !== 3'b010) begin errors++; $display("FAIL mid_tens: got %h/%b want 6d/010", seg, an); end
    $display("reset_midconv 50: errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_ovf();
    test_back_to_back();
    test_enable();
    test_leading_zero();
    test_reset_midconv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
